// File: rtl/clock_divider_multi.sv
`default_nettype none
// ============================================================================
// Module      : clock_divider_multi
// Description : NUM_CH programmable 50%-duty clock dividers sharing one input
//               clock. Each channel's half-period is reloadable through a
//               valid/ready port and takes effect at the channel's next wrap.
//               Optional tick output enabled by defining CLKDIV_TICK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_divider_multi #(
  parameter  int CLK_IN_HZ  = 50_000_000,
  parameter  int DEFAULT_HZ = 1,
  parameter  int NUM_CH     = 4,
  parameter  int CNT_W      = 26,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] clk_out
`ifdef CLKDIV_TICK_EN
  ,
  output logic [NUM_CH-1:0] tick
`endif
);

  localparam logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(CLK_IN_HZ / (2 * DEFAULT_HZ));

  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_pend;
  logic              w_accept;
  logic [CNT_W-1:0]  w_cfg_half;

  // Half-periods of 0 and 1 both mean "toggle every cycle".
  assign w_cfg_half = (cfg_half < CNT_W'(2)) ? CNT_W'(1) : cfg_half;

  // An out-of-range channel selects nothing, so it is always ready and dropped.
  assign cfg_ready = ~|(w_sel & w_pend);
  assign w_accept  = cfg_valid & cfg_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_pend_half;
    logic             r_pend;
    logic             r_clk;
    logic             w_wrap;
    logic             w_load;

    assign w_sel[i] = (cfg_ch == CH_W'(i));
    assign w_wrap   = (r_cnt == r_half - CNT_W'(1));
    assign w_load   = w_accept & w_sel[i];

    always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
        r_cnt       <= '0;
        r_half      <= DEFAULT_HALF;
        r_pend_half <= DEFAULT_HALF;
        r_pend      <= 1'b0;
        r_clk       <= 1'b0;
      end else begin
        if (ch_en[i]) begin
          if (w_wrap) begin
            r_cnt <= '0;
            r_clk <= ~r_clk;
            if (r_pend) begin
              r_half <= r_pend_half;
              r_pend <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end else begin
          // Disabled: count is discarded and any pending reload lands at once.
          r_cnt <= '0;
          r_clk <= 1'b0;
          if (r_pend) begin
            r_half <= r_pend_half;
            r_pend <= 1'b0;
          end
        end
        // A load only happens while r_pend is clear, so it never races an apply.
        if (w_load) begin
          r_pend_half <= w_cfg_half;
          r_pend      <= 1'b1;
        end
      end
    end

    assign clk_out[i] = r_clk;
    assign w_pend[i]  = r_pend;

`ifdef CLKDIV_TICK_EN
    logic r_tick;

    // Marks the first cycle of each high phase.
    always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
        r_tick <= 1'b0;
      end else begin
        r_tick <= ch_en[i] & w_wrap & ~r_clk;
      end
    end

    assign tick[i] = r_tick;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_divider_multi
// Description : Randomized self-checking bench for clock_divider_multi against
//               an elapsed-cycle reference model (NUM_CH=2, DEFAULT_HALF=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_divider_multi;

  localparam int NUM_CH     = 2;
  localparam int CNT_W      = 8;
  localparam int CLK_IN_HZ  = 16;
  localparam int DEFAULT_HZ = 2;
  localparam int DEF_HALF   = CLK_IN_HZ / (2 * DEFAULT_HZ);

  logic              clk_in = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] ch_en;
  logic              cfg_valid;
  logic [0:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_half;
  logic              cfg_ready;
  logic [NUM_CH-1:0] clk_out;
`ifdef CLKDIV_TICK_EN
  logic [NUM_CH-1:0] tick;
`endif

  clock_divider_multi #(
    .CLK_IN_HZ (CLK_IN_HZ),
    .DEFAULT_HZ(DEFAULT_HZ),
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .ch_en    (ch_en),
    .cfg_valid(cfg_valid),
    .cfg_ch   (cfg_ch),
    .cfg_half (cfg_half),
    .cfg_ready(cfg_ready),
    .clk_out  (clk_out)
`ifdef CLKDIV_TICK_EN
    ,
    .tick     (tick)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: cycles elapsed in the current half, active half length,
  // at most one queued reload per channel, output level and tick.
  int m_elapsed [NUM_CH];
  int m_half    [NUM_CH];
  int m_next    [NUM_CH];
  bit m_has_next[NUM_CH];
  bit m_out     [NUM_CH];
  bit m_tick    [NUM_CH];

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0d required %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_elapsed[c]  = 0;
      m_half[c]     = DEF_HALF;
      m_next[c]     = 0;
      m_has_next[c] = 1'b0;
      m_out[c]      = 1'b0;
      m_tick[c]     = 1'b0;
    end
  endtask

  task automatic model_step();
    bit accept;
    accept = cfg_valid && !m_has_next[cfg_ch];
    for (int c = 0; c < NUM_CH; c++) begin
      m_tick[c] = 1'b0;
      if (ch_en[c]) begin
        m_elapsed[c]++;
        if (m_elapsed[c] == m_half[c]) begin
          m_elapsed[c] = 0;
          m_tick[c]    = !m_out[c];
          m_out[c]     = !m_out[c];
          if (m_has_next[c]) begin
            m_half[c]     = m_next[c];
            m_has_next[c] = 1'b0;
          end
        end
      end else begin
        m_elapsed[c] = 0;
        m_out[c]     = 1'b0;
        if (m_has_next[c]) begin
          m_half[c]     = m_next[c];
          m_has_next[c] = 1'b0;
        end
      end
    end
    if (accept) begin
      m_next[cfg_ch]     = (int'(cfg_half) < 2) ? 1 : int'(cfg_half);
      m_has_next[cfg_ch] = 1'b1;
    end
  endtask

  task automatic check_outputs();
    for (int c = 0; c < NUM_CH; c++) begin
      check_value($sformatf("clk_out[%0d]", c), 32'(clk_out[c]), 32'(m_out[c]));
`ifdef CLKDIV_TICK_EN
      check_value($sformatf("tick[%0d]", c), 32'(tick[c]), 32'(m_tick[c]));
`endif
    end
  endtask

  // Called at a falling edge; returns at a falling edge after n cycles.
  task automatic run_cycles(input int n, input bit rnd);
    for (int k = 0; k < n; k++) begin
      if (rnd) begin
        for (int c = 0; c < NUM_CH; c++)
          if ($urandom_range(0, 11) == 0) ch_en[c] = ~ch_en[c];
        cfg_valid = ($urandom_range(0, 3) == 0);
        cfg_ch    = 1'($urandom_range(0, 1));
        cfg_half  = CNT_W'($urandom_range(0, 9));
      end
      #1;
      check_value("cfg_ready", 32'(cfg_ready), 32'(!m_has_next[cfg_ch]));
      @(posedge clk_in);
      model_step();
      @(negedge clk_in);
      check_outputs();
    end
  endtask

  initial begin
    reset     = 1'b0;
    ch_en     = '0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_half  = '0;
    model_reset();
    #1;
    check_value("reset clk_out", 32'(clk_out), 32'(0));
    check_value("reset cfg_ready", 32'(cfg_ready), 32'(1));

    @(negedge clk_in);
    reset = 1'b1;
    ch_en = 2'b11;
    run_cycles(24, 1'b0);

    // Directed reload on ch0 mid-half followed by a stalled second request.
    run_cycles(1, 1'b0);
    cfg_valid = 1'b1;
    cfg_ch    = 1'b0;
    cfg_half  = CNT_W'(2);
    run_cycles(1, 1'b0);
    cfg_half  = CNT_W'(0);
    run_cycles(6, 1'b0);
    cfg_valid = 1'b0;
    run_cycles(12, 1'b0);

    run_cycles(1500, 1'b1);

    // Asynchronous reset between edges, with a reload left pending on ch1.
    cfg_valid = 1'b1;
    cfg_ch    = 1'b1;
    cfg_half  = CNT_W'(7);
    ch_en     = 2'b11;
    run_cycles(2, 1'b0);
    cfg_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_value("async clk_out", 32'(clk_out), 32'(0));
`ifdef CLKDIV_TICK_EN
    check_value("async tick", 32'(tick), 32'(0));
`endif
    check_value("async cfg_ready", 32'(cfg_ready), 32'(1));
    @(posedge clk_in);
    @(negedge clk_in);
    check_value("held clk_out", 32'(clk_out), 32'(0));
    reset = 1'b1;
    run_cycles(30, 1'b0);
    run_cycles(500, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
